// File: rtl/cache_fill_arbiter.sv
// ---- cache_fill_arbiter: arbitrates block fills for NUM_CH caches onto one pipelined memory (rev 1.0) ----
`default_nettype none

module cache_fill_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WORDS     = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          miss_req,
  input  logic [NUM_CH*ADDR_W-1:0]   miss_addr,
  output logic [NUM_CH-1:0]          fsm_busy,
  output logic [NUM_CH-1:0]          write_data_array,
  output logic [NUM_CH-1:0]          write_tag_array,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic [DATA_W-1:0]          fill_data,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       mem_data_valid
);

  localparam int STRIDE = DATA_W / 8;
  localparam int OFF_W  = $clog2(WORDS * STRIDE);
  localparam int WW     = $clog2(WORDS);
  localparam int CW     = WW + 1;
  localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CW-1:0]     WORDS_C   = CW'(WORDS);
  localparam logic [CW-1:0]     LAST_WORD = CW'(WORDS - 1);
  localparam logic [GW:0]       NUM_CH_W  = (GW + 1)'(NUM_CH);
  localparam logic [GW-1:0]     LAST_CH   = GW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_COOL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       ic_q, ic_d;
  logic [CW-1:0]       rc_q, rc_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  logic [GW-1:0]       rr_off;
  logic [NUM_CH-1:0]   rot;
  logic [GW:0]         sum;
  logic [GW-1:0]       pick;
  logic                pick_vld;
  logic [ADDR_W-1:0]   pick_addr;
  logic                issue;
  logic                wr;
  logic                last;
  logic [NUM_CH-1:0]   sel;

  // Rotate requests so the search always starts at bit 0; fixed priority uses no rotation.
  assign rr_off = (PRIO_MODE == 1) ? rr_q : '0;

  always_comb begin
    rot      = NUM_CH'({miss_req, miss_req} >> rr_off);
    pick_vld = 1'b0;
    pick     = '0;
    sum      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!pick_vld && rot[k]) begin
        pick_vld = 1'b1;
        sum      = {1'b0, rr_off} + (GW + 1)'(k);
        if (sum >= NUM_CH_W) begin
          sum = sum - NUM_CH_W;
        end
        pick = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pick == GW'(k)) begin
        pick_addr = miss_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign issue = (state_q == S_FILL) && (ic_q != WORDS_C);
  assign wr    = (state_q == S_FILL) && mem_data_valid && (rc_q != WORDS_C);
  assign last  = wr && (rc_q == LAST_WORD);
  assign sel   = NUM_CH'(1) << grant_q;

  always_comb begin
    state_d = state_q;
    ic_d    = ic_q;
    rc_d    = rc_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    base_d  = base_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_FILL;
          grant_d = pick;
          base_d  = pick_addr & BASE_MASK;
          ic_d    = '0;
          rc_d    = '0;
        end
      end
      S_FILL: begin
        if (issue) begin
          ic_d = ic_q + 1'b1;
        end
        if (wr) begin
          rc_d = rc_q + 1'b1;
        end
        if (last) begin
          state_d = S_COOL;
          rr_d    = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
        end
      end
      S_COOL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ic_q    <= '0;
      rc_q    <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      rc_q    <= rc_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
    end
  end

  // Outputs are zero outside an active issue/write so the memory and caches see clean idle values.
  assign mem_en           = issue;
  assign mem_addr         = issue ? (base_q + ADDR_W'(ic_q[WW-1:0]) * ADDR_W'(STRIDE)) : '0;
  assign write_data_array = wr ? sel : '0;
  assign write_tag_array  = last ? sel : '0;
  assign fill_word        = wr ? rc_q[WW-1:0] : '0;
  assign fill_data        = wr ? mem_data : '0;
  assign fsm_busy         = miss_req | ((state_q != S_IDLE) ? sel : '0);

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
// ---- tb_cache_fill_arbiter: directed self-checking bench, fixed-priority and round-robin instances (rev 1.0) ----
`default_nettype none

module tb_cache_fill_arbiter;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  miss_req  [2];
  logic [31:0] miss_addr [2];
  logic [1:0]  busy [2];
  logic [1:0]  wda  [2];
  logic [1:0]  wta  [2];
  logic [2:0]  fw   [2];
  logic [15:0] fd   [2];
  logic [15:0] maddr[2];
  logic [15:0] mdata[2];
  logic        men  [2];
  logic        mval [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_fill_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .WORDS(8), .PRIO_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req[0]), .miss_addr(miss_addr[0]),
    .fsm_busy(busy[0]), .write_data_array(wda[0]), .write_tag_array(wta[0]),
    .fill_word(fw[0]), .fill_data(fd[0]), .mem_en(men[0]), .mem_addr(maddr[0]),
    .mem_data(mdata[0]), .mem_data_valid(mval[0])
  );

  cache_fill_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .WORDS(8), .PRIO_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req[1]), .miss_addr(miss_addr[1]),
    .fsm_busy(busy[1]), .write_data_array(wda[1]), .write_tag_array(wta[1]),
    .fill_word(fw[1]), .fill_data(fd[1]), .mem_en(men[1]), .mem_addr(maddr[1]),
    .mem_data(mdata[1]), .mem_data_valid(mval[1])
  );

  // Memory model: fixed latency LAT, optional gap cycles after each returned word,
  // data word = address ^ 16'h5A5A, optional forced valid with 16'hBEEF.
  logic [15:0] qa [2][16];
  int          qt [2][16];
  int          hd  [2] = '{0, 0};
  int          tl  [2] = '{0, 0};
  int          hold[2] = '{0, 0};
  int          gap [2] = '{0, 0};
  bit          inj [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        hd[d] = 0; tl[d] = 0; hold[d] = 0; mval[d] = 1'b0; mdata[d] = '0;
      end else begin
        if (men[d]) begin
          qa[d][tl[d] % 16] = maddr[d];
          qt[d][tl[d] % 16] = cyc + LAT;
          tl[d] = tl[d] + 1;
        end
        mval[d]  = 1'b0;
        mdata[d] = '0;
        if (inj[d]) begin
          mval[d] = 1'b1; mdata[d] = 16'hBEEF;
        end else if (hold[d] > 0) begin
          hold[d] = hold[d] - 1;
        end else if (hd[d] != tl[d] && qt[d][hd[d] % 16] <= cyc) begin
          mval[d]  = 1'b1;
          mdata[d] = qa[d][hd[d] % 16] ^ 16'h5A5A;
          hd[d]    = hd[d] + 1;
          hold[d]  = gap[d];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_quiet(input int d);
    chk("quiet_mem_en", 32'(men[d]), 32'd0);
    chk("quiet_mem_addr", 32'(maddr[d]), 32'd0);
    chk("quiet_wda", 32'(wda[d]), 32'd0);
    chk("quiet_wta", 32'(wta[d]), 32'd0);
    chk("quiet_fill_word", 32'(fw[d]), 32'd0);
    chk("quiet_fill_data", 32'(fd[d]), 32'd0);
  endtask

  // Follows one block fill of channel ch on instance d until its tag strobe.
  task automatic run_fill(input int d, input int ch, input logic [15:0] base,
                          output int t_iss0, output int t_iss_last,
                          output int t_wr0, output int t_tag);
    int ni, nw, oth;
    bit done;
    ni = 0; nw = 0; oth = 1 - ch; done = 1'b0;
    t_iss0 = -1; t_iss_last = -1; t_wr0 = -1; t_tag = -1;
    for (int k = 1; k <= 60 && !done; k++) begin
      step();
      if (men[d]) begin
        chk("issue_addr", 32'(maddr[d]), 32'(base + 16'(2 * ni)));
        if (ni == 0) t_iss0 = k;
        t_iss_last = k;
        ni++;
      end
      if (wda[d] != 2'b00) begin
        chk("wr_channel", 32'(wda[d]), 32'(1 << ch));
        chk("fill_word", 32'(fw[d]), 32'(nw));
        chk("fill_data", 32'(fd[d]), 32'((base + 16'(2 * nw)) ^ 16'h5A5A));
        if (nw == 0) t_wr0 = k;
        nw++;
      end
      chk("busy_own", 32'(busy[d][ch]), 32'd1);
      if (miss_req[d][oth]) chk("busy_waiting", 32'(busy[d][oth]), 32'd1);
      if (wta[d] != 2'b00) begin
        chk("tag_channel", 32'(wta[d]), 32'(1 << ch));
        chk("tag_on_last_word", 32'(nw), 32'd8);
        t_tag = k;
        done = 1'b1;
      end
    end
    chk("fill_completed", 32'(done), 32'd1);
    chk("issue_count", 32'(ni), 32'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b, c, t, nw;
    miss_req[0] = '0; miss_req[1] = '0;
    miss_addr[0] = '0; miss_addr[1] = '0;

    // Reset state
    step(); step();
    chk_quiet(0); chk_quiet(1);
    rst_n = 1'b1;
    step();
    chk_quiet(0); chk_quiet(1);
    chk("reset_busy", 32'(busy[0]), 32'd0);

    // Ch1 alone, addr 0x1234, L=4: exact cycle timing
    miss_addr[0] = {16'h1234, 16'h0000};
    miss_req[0]  = 2'b10;
    #1;
    chk("busy_same_cycle", 32'(busy[0][1]), 32'd1);
    chk("busy_ch0_idle", 32'(busy[0][0]), 32'd0);
    run_fill(0, 1, 16'h1230, a, b, c, t);
    chk("first_issue_cycle", 32'(a), 32'd1);
    chk("last_issue_cycle", 32'(b), 32'd8);
    chk("first_write_cycle", 32'(c), 32'd5);
    chk("tag_cycle", 32'(t), 32'd12);
    miss_req[0] = 2'b00;
    step();
    chk("cool_busy", 32'(busy[0][1]), 32'd1);
    chk("cool_wda", 32'(wda[0]), 32'd0);
    chk("cool_wta", 32'(wta[0]), 32'd0);
    step();
    chk("busy_drop", 32'(busy[0][1]), 32'd0);
    step();

    // Fixed priority: both miss, ch0 first then ch1
    miss_addr[0] = {16'h2000, 16'h0040};
    miss_req[0]  = 2'b11;
    run_fill(0, 0, 16'h0040, a, b, c, t);
    miss_req[0] = 2'b10;
    run_fill(0, 1, 16'h2000, a, b, c, t);
    miss_req[0] = 2'b00;
    step(); step(); step();

    // Valid while idle is ignored
    inj[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_valid_wda", 32'(wda[0]), 32'd0);
      chk("idle_valid_wta", 32'(wta[0]), 32'd0);
      chk("idle_valid_mem_en", 32'(men[0]), 32'd0);
    end
    inj[0] = 1'b0;
    step();
    miss_addr[0] = {16'h0000, 16'h0102};
    miss_req[0]  = 2'b01;
    run_fill(0, 0, 16'h0100, a, b, c, t);
    miss_req[0] = 2'b00;
    step(); step(); step();

    // Two-cycle gaps between valids
    gap[0] = 2;
    miss_addr[0] = {16'h3456, 16'h0000};
    miss_req[0]  = 2'b10;
    run_fill(0, 1, 16'h3450, a, b, c, t);
    chk("gap_first_write", 32'(c), 32'd5);
    chk("gap_tag_cycle", 32'(t), 32'd26);
    miss_req[0] = 2'b00;
    gap[0] = 0;
    step(); step(); step();

    // Round-robin: both keep re-missing, grants alternate
    miss_addr[1] = {16'h2000, 16'h0040};
    miss_req[1]  = 2'b11;
    run_fill(1, 0, 16'h0040, a, b, c, t);
    run_fill(1, 1, 16'h2000, a, b, c, t);
    run_fill(1, 0, 16'h0040, a, b, c, t);
    run_fill(1, 1, 16'h2000, a, b, c, t);
    miss_req[1] = 2'b00;
    step(); step(); step();

    // Reset after the 3rd valid of a ch0 fill, then restart from word 0
    miss_addr[0] = {16'h0000, 16'h0048};
    miss_req[0]  = 2'b01;
    nw = 0;
    for (int k = 0; k < 30 && nw < 3; k++) begin
      step();
      if (wda[0] != 2'b00) nw++;
      chk("no_early_tag", 32'(wta[0]), 32'd0);
    end
    chk("third_valid_seen", 32'(nw), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet(0);
    chk("reset_busy_ch1", 32'(busy[0][1]), 32'd0);
    @(negedge clk);
    #2;
    chk("reset_hold_tag", 32'(wta[0]), 32'd0);
    rst_n = 1'b1;
    run_fill(0, 0, 16'h0040, a, b, c, t);
    chk("restart_first_issue", 32'(a), 32'd1);
    chk("restart_first_write", 32'(c), 32'd5);
    miss_req[0] = 2'b00;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
Parametrised successor to the single-requester cache miss fill FSM. It arbitrates block fills for NUM_CH cache channels (ch0 = I-cache, ch1 = D-cache by default) onto one shared, pipelined, multi-cycle main memory. It issues one word address per cycle and writes each returned word into the granted cache's data array. The tag write is raised on the last word. The block sits between the caches' miss/stall logic and the memory4c-style main memory.

Parameters:
NUM_CH, 2, number of cache channels requesting fills (>=1)
ADDR_W, 16, byte address width
DATA_W, 16, memory/cache word width (multiple of 8)
WORDS, 8, words per cache block (power of 2, >=2)
PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
miss_req  in  NUM_CH  per-channel miss detected, level, held by requester until serviced
miss_addr  in  NUM_CH*ADDR_W  per-channel miss byte address, ch i at bits [i*ADDR_W +: ADDR_W]
fsm_busy  out  NUM_CH  per-channel stall to the pipeline
write_data_array  out  NUM_CH  one-cycle data-array write strobe to the granted cache
write_tag_array  out  NUM_CH  one-cycle tag-array write strobe to the granted cache
fill_word  out  clog2(WORDS)  word index within the block for the current data write
fill_data  out  DATA_W  word to write, equals mem_data
mem_en  out  1  memory read request, one address per cycle
mem_addr  out  ADDR_W  memory byte address
mem_data  in  DATA_W  memory read data
mem_data_valid  in  1  mem_data valid this cycle

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, issue counter ic=0, receive counter rc=0, grant=0, rr pointer=0. All outputs are 0, including mem_addr and fill_word.
- Stride S = DATA_W/8 bytes. Block base = miss_addr with its low clog2(WORDS*S) bits cleared, latched at grant.
- States are IDLE, FILL and COOL.
- IDLE: if any miss_req bit is set, select the grant per PRIO_MODE, latch grant and base, clear ic and rc, and go to FILL at the next edge. Otherwise stay in IDLE.
- Round-robin: search starts at the rr pointer. On completion rr = grant+1, wrapping modulo NUM_CH.
- FILL issue side: while ic<WORDS, drive mem_en=1 and mem_addr=base+ic*S, then ic++. When ic==WORDS, drive mem_en=0 and mem_addr=0.
- FILL receive side: each cycle with mem_data_valid=1 and rc<WORDS:
  - write_data_array[grant]=1, fill_word=rc, fill_data=mem_data, then rc++.
  - On the valid with rc==WORDS-1, write_tag_array[grant]=1 in the same cycle and go to COOL.
- Issue and receive overlap. Gaps in mem_data_valid are tolerated; rc advances only on a valid.
- COOL: lasts one cycle with no strobes, then returns to IDLE. This lets the requester drop its miss_req after the tag write so the stale miss is not re-granted.
- mem_data_valid in IDLE or COOL, or with rc==WORDS, is ignored: no strobes and no counter change.
- fsm_busy[i] = miss_req[i] OR (state!=IDLE AND grant==i). This is combinational, so the stall is asserted in the same cycle as the miss.
- Non-granted requesters stay busy and wait; no request is dropped.
- miss_req[grant] deasserting mid-fill does not abort the fill; it completes and writes the tag.
- Changes to miss_addr after grant are ignored.
- Reset mid-fill aborts immediately with no tag write. A still-pending miss is refilled from word 0 after reset.
- Strobes are one-hot within the granted channel; at most one channel is strobed per cycle.
- Latency for memory latency L cycles and no gaps:
  - miss at cycle 0 gives first mem_en at cycle 1 and last issue at cycle WORDS.
  - Last data and tag write occur at cycle WORDS+L.
  - fsm_busy drops at cycle WORDS+L+2 if miss_req has fallen.

Test Plan:
- Ch1 miss only, addr 0x1234, L=4: mem_addr 0x1230,0x1232,…,0x123E on cycles 1–8. write_data_array[1] pulses with fill_word 0..7 on cycles 5–12. write_tag_array[1] fires on cycle 12. fsm_busy[1] is high from cycle 0, ch0 sees no strobes.
- Ch0 addr 0x0040 and ch1 addr 0x2000 missing together, PRIO_MODE=0: ch0 block 0x0040–0x004E is filled first, then ch1 block 0x2000–0x200E. fsm_busy[1] stays high throughout.
- PRIO_MODE=1 with both channels re-missing after every fill: grant order is 0,1,0,1; no channel is served twice in a row while the other waits.
- mem_data_valid=1 with mem_data=0xBEEF while IDLE: no write_data_array or write_tag_array strobe, and the counters stay 0.
- Memory inserts 2-cycle gaps between valids: fill_word is still 0..7 in order, and the tag strobe occurs only with the 8th valid.
- rst_n pulsed low after the 3rd valid of a ch0 fill: all outputs go to 0 immediately with no tag strobe. With miss_req[0] still high after release, the fill restarts from base word 0.
